pos_input_ring_node_buffered: RTL
=================================

Name: pos_input_ring_node_buffered

Overview:
- Next-generation position-input ring node: one hop of the position broadcast ring feeding a PE.
- Forwards ring packets with lifetime countdown.
- Delivers packets whose source cell is a 3D neighbour (periodic wrap) of the node's home cell into an output FIFO toward the PE.
- Injects local packets from an input FIFO into free ring slots; a hit packet that meets a full PE FIFO is recirculated, not lost.

Parameters:
- OFFSET_W, 27, offset packet width.
- GCID_W, 3, per-dimension global cell id width.
- CID_W, 2, per-dimension neighbour cell id width.
- LT_W, 5, lifetime width.
- INIT_LIFETIME, 8, lifetime stamped on injection (ring length); must be ≥1.
- GRID_X/GRID_Y/GRID_Z, 4/4/4, cells per dimension, used for wrap.
- HOME_X/HOME_Y/HOME_Z, 0/0/0, this node's home cell.
- INJ_DEPTH, 8, local injection FIFO depth, power of 2.
- PE_DEPTH, 4, PE output FIFO depth, power of 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- i_ring_offset_pkt  in  OFFSET_W  packet from previous node.
- i_ring_gcid  in  3*GCID_W  source cell {z,y,x}.
- i_ring_lifetime  in  LT_W  remaining hops; nonzero means valid.
- i_local_offset_pkt  in  OFFSET_W  local packet from pos cache.
- i_local_gcid  in  3*GCID_W  local packet cell.
- i_local_valid  in  1  local push request.
- o_local_ready  out  1  injection FIFO not full.
- o_offset_pkt_to_ring  out  OFFSET_W  to next node.
- o_gcid_to_ring  out  3*GCID_W  to next node.
- o_lifetime_to_ring  out  LT_W  to next node; 0 means empty slot.
- o_pos_pkt_to_pe  out  OFFSET_W+3*CID_W  {cid_z,cid_y,cid_x,offset}.
- o_pos_pkt_to_pe_valid  out  1  PE FIFO not empty.
- i_pe_ready  in  1  PE accepts the head entry.
- o_dirty_feedback  out  1  one-cycle pulse when a hit is deferred (recirculated).
- o_retry_count  out  16  saturating count of deferred hits.

Behaviour:
- Reset: all ring outputs 0, both FIFOs empty, o_pos_pkt_to_pe_valid=0, o_dirty_feedback=0, o_retry_count=0, o_local_ready=1. Reset mid-traffic discards all in-flight and buffered packets.
- Ring path is registered: input to output latency is exactly 1 cycle.
- Incoming slot is valid iff i_ring_lifetime≠0.
- Per-dimension delta d=(src−home) mod GRID. Hit iff every dimension has d∈{0,1,GRID−1}.
- CID mapping per dimension: d=GRID−1→0, d=0→1, d=1→2.
- With GRID=1 every valid packet hits with cid=1. GRID=2: d=1 maps to cid 2.
- Hit and PE FIFO not full (registered full flag, evaluated before this cycle's pop): write to PE FIFO; forward with lifetime−1.
- Hit and PE FIFO full: do not write; forward with lifetime unchanged; pulse o_dirty_feedback; o_retry_count += 1, saturating at 0xFFFF.
- No hit: forward with lifetime−1.
- A forwarded lifetime of 0 means the slot is freed: output gcid and packet are 0.
- Outgoing slot is free iff the incoming lifetime is 0, or it is 1 and the packet is not deferred.
- Injection: when the outgoing slot is free and the injection FIFO is not empty, pop its head. Output that packet with INIT_LIFETIME in the same registered stage. Ring traffic always has priority.
- Injection FIFO: push on i_local_valid && o_local_ready. Simultaneous push and pop is legal, including at full when the pop occurs, but ready is derived from the registered full flag only. A push while not ready is ignored.
- PE FIFO: first-word fall-through. Pop on o_pos_pkt_to_pe_valid && i_pe_ready. Simultaneous write and pop is legal when not full.
- Pointers wrap modulo depth; counts are depth+1 wide.

Test Plan:
- Reset, idle ring, no local traffic -> all outputs 0, o_local_ready=1 for 20 cycles.
- HOME=(0,0,0), GRID=4; ring packet gcid (3,1,0), lifetime 5, i_pe_ready=1 -> next cycle PE FIFO receives cid {z=0,y=2,x=1}, valid=1; ring output lifetime 4.
- Ring packet gcid (2,2,2), lifetime 1 -> no PE write; ring output lifetime 0; a queued local packet is injected the same cycle with lifetime 8.
- i_pe_ready=0; drive 5 hitting packets -> first 4 fill the PE FIFO; 5th forwarded with unchanged lifetime, o_dirty_feedback pulses once, o_retry_count=1.
- Push 9 local packets while the ring is fully occupied (lifetime 3 every cycle) -> 8 accepted, o_local_ready=0, none injected; once the ring goes idle they drain one per cycle in FIFO order.
- Assert rst asynchronously mid-stream with both FIFOs partially full -> outputs 0 immediately, counts 0, o_local_ready=1.

Source files
------------

// File: rtl/pos_input_ring_node_buffered.sv
// ---------------------------------------------------------------------------
// pos_input_ring_node_buffered
//
// One hop of the position broadcast ring. Each cycle the incoming ring slot
// is registered to the next node with its lifetime decremented. A packet
// whose source cell is a periodic 3D neighbour of the home cell is also
// copied into a first-word-fall-through FIFO toward the PE. If that FIFO is
// full, the packet is recirculated with its lifetime unchanged so it comes
// around again. Free ring slots are filled from a local injection FIFO.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   i_ring_*                 slot from previous node (lifetime 0 = empty)
//   i_local_*, o_local_ready push side of the local injection FIFO
//   o_*_to_ring              registered slot to next node
//   o_pos_pkt_to_pe(_valid)  PE FIFO head {cid_z,cid_y,cid_x,offset}
//   i_pe_ready               PE accepts the head entry
//   o_dirty_feedback         one-cycle pulse when a hit is deferred
//   o_retry_count            saturating count of deferred hits
// ---------------------------------------------------------------------------
module pos_input_ring_node_buffered #(
    parameter int OFFSET_W      = 27,
    parameter int GCID_W        = 3,
    parameter int CID_W         = 2,
    parameter int LT_W          = 5,
    parameter int INIT_LIFETIME = 8,
    parameter int GRID_X        = 4,
    parameter int GRID_Y        = 4,
    parameter int GRID_Z        = 4,
    parameter int HOME_X        = 0,
    parameter int HOME_Y        = 0,
    parameter int HOME_Z        = 0,
    parameter int INJ_DEPTH     = 8,
    parameter int PE_DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [OFFSET_W-1:0]          i_ring_offset_pkt,
    input  logic [3*GCID_W-1:0]          i_ring_gcid,
    input  logic [LT_W-1:0]              i_ring_lifetime,
    input  logic [OFFSET_W-1:0]          i_local_offset_pkt,
    input  logic [3*GCID_W-1:0]          i_local_gcid,
    input  logic                         i_local_valid,
    output logic                         o_local_ready,
    output logic [OFFSET_W-1:0]          o_offset_pkt_to_ring,
    output logic [3*GCID_W-1:0]          o_gcid_to_ring,
    output logic [LT_W-1:0]              o_lifetime_to_ring,
    output logic [OFFSET_W+3*CID_W-1:0]  o_pos_pkt_to_pe,
    output logic                         o_pos_pkt_to_pe_valid,
    input  logic                         i_pe_ready,
    output logic                         o_dirty_feedback,
    output logic [15:0]                  o_retry_count
);

    localparam int INJ_AW = $clog2(INJ_DEPTH);
    localparam int PE_AW  = $clog2(PE_DEPTH);
    localparam int INJ_W  = 3*GCID_W + OFFSET_W;
    localparam int PE_W   = OFFSET_W + 3*CID_W;

    localparam logic [INJ_AW:0] INJ_FULL_CNT = (INJ_AW+1)'(INJ_DEPTH);
    localparam logic [PE_AW:0]  PE_FULL_CNT  = (PE_AW+1)'(PE_DEPTH);
    localparam logic [LT_W-1:0] INIT_LT      = LT_W'(INIT_LIFETIME);

    // Returns {hit, cid} for one dimension. d==0 is tested first so GRID=1
    // maps to cid 1, and d==1 before GRID-1 so GRID=2 maps d=1 to cid 2.
    function automatic logic [CID_W:0] map_dim(input int src, input int home, input int grid);
        int d;
        d = ((src % grid) + grid - (home % grid)) % grid;
        if (d == 0)             return {1'b1, CID_W'(1)};
        else if (d == 1)        return {1'b1, CID_W'(2)};
        else if (d == grid - 1) return {1'b1, CID_W'(0)};
        else                    return '0;
    endfunction

    // ---------------- state ----------------
    logic [INJ_W-1:0]      r_inj_mem [INJ_DEPTH];
    logic [INJ_AW-1:0]     r_inj_wr_ptr, r_inj_rd_ptr;
    logic [INJ_AW:0]       r_inj_count;
    logic                  r_inj_full;

    logic [PE_W-1:0]       r_pe_mem [PE_DEPTH];
    logic [PE_AW-1:0]      r_pe_wr_ptr, r_pe_rd_ptr;
    logic [PE_AW:0]        r_pe_count;
    logic                  r_pe_full;

    logic [OFFSET_W-1:0]   r_out_offset;
    logic [3*GCID_W-1:0]   r_out_gcid;
    logic [LT_W-1:0]       r_out_lifetime;
    logic                  r_dirty;
    logic [15:0]           r_retry_count;

    // ---------------- datapath decode ----------------
    logic [CID_W:0]        w_dim_x, w_dim_y, w_dim_z;
    logic                  w_hit, w_defer, w_pe_wr, w_pe_pop;
    logic [LT_W-1:0]       w_fwd_lt;
    logic                  w_slot_free, w_inj_push, w_inj_pop;
    logic [INJ_AW:0]       w_inj_count_nxt;
    logic [PE_AW:0]        w_pe_count_nxt;
    logic [INJ_W-1:0]      w_inj_head;

    // NOTE: combinational logic uses blocking '=' with a default for every
    // target up front, so no path through the block can infer a latch.
    always_comb begin
        w_dim_x  = map_dim(int'(i_ring_gcid[GCID_W-1:0]),          HOME_X, GRID_X);
        w_dim_y  = map_dim(int'(i_ring_gcid[2*GCID_W-1:GCID_W]),   HOME_Y, GRID_Y);
        w_dim_z  = map_dim(int'(i_ring_gcid[3*GCID_W-1:2*GCID_W]), HOME_Z, GRID_Z);
        w_hit    = (i_ring_lifetime != '0) && w_dim_x[CID_W] && w_dim_y[CID_W] && w_dim_z[CID_W];
        // Full flag is the registered one: a same-cycle pop does not make room.
        w_defer  = w_hit && r_pe_full;
        w_pe_wr  = w_hit && !r_pe_full;
        w_pe_pop = o_pos_pkt_to_pe_valid && i_pe_ready;

        w_fwd_lt = '0;
        if (i_ring_lifetime != '0)
            w_fwd_lt = w_defer ? i_ring_lifetime : i_ring_lifetime - LT_W'(1);
        w_slot_free = (w_fwd_lt == '0);

        w_inj_push = i_local_valid && !r_inj_full;
        w_inj_pop  = w_slot_free && (r_inj_count != '0);
        w_inj_head = r_inj_mem[r_inj_rd_ptr];

        w_inj_count_nxt = r_inj_count;
        if (w_inj_push && !w_inj_pop)      w_inj_count_nxt = r_inj_count + (INJ_AW+1)'(1);
        else if (!w_inj_push && w_inj_pop) w_inj_count_nxt = r_inj_count - (INJ_AW+1)'(1);

        w_pe_count_nxt = r_pe_count;
        if (w_pe_wr && !w_pe_pop)          w_pe_count_nxt = r_pe_count + (PE_AW+1)'(1);
        else if (!w_pe_wr && w_pe_pop)     w_pe_count_nxt = r_pe_count - (PE_AW+1)'(1);
    end

    // NOTE: FIFO storage has no reset; validity comes solely from the
    // counts, which are reset, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (w_inj_push) r_inj_mem[r_inj_wr_ptr] <= {i_local_gcid, i_local_offset_pkt};
        if (w_pe_wr)    r_pe_mem[r_pe_wr_ptr]   <= {w_dim_z[CID_W-1:0], w_dim_y[CID_W-1:0],
                                                    w_dim_x[CID_W-1:0], i_ring_offset_pkt};
    end

    // NOTE: sequential state uses non-blocking '<=' so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inj_wr_ptr   <= '0;
            r_inj_rd_ptr   <= '0;
            r_inj_count    <= '0;
            r_inj_full     <= 1'b0;
            r_pe_wr_ptr    <= '0;
            r_pe_rd_ptr    <= '0;
            r_pe_count     <= '0;
            r_pe_full      <= 1'b0;
            r_out_offset   <= '0;
            r_out_gcid     <= '0;
            r_out_lifetime <= '0;
            r_dirty        <= 1'b0;
            r_retry_count  <= '0;
        end else begin
            // Pointers are power-of-2 wide, so increment wraps naturally.
            if (w_inj_push) r_inj_wr_ptr <= r_inj_wr_ptr + INJ_AW'(1);
            if (w_inj_pop)  r_inj_rd_ptr <= r_inj_rd_ptr + INJ_AW'(1);
            r_inj_count <= w_inj_count_nxt;
            r_inj_full  <= (w_inj_count_nxt == INJ_FULL_CNT);

            if (w_pe_wr)  r_pe_wr_ptr <= r_pe_wr_ptr + PE_AW'(1);
            if (w_pe_pop) r_pe_rd_ptr <= r_pe_rd_ptr + PE_AW'(1);
            r_pe_count <= w_pe_count_nxt;
            r_pe_full  <= (w_pe_count_nxt == PE_FULL_CNT);

            if (w_inj_pop) begin
                r_out_lifetime <= INIT_LT;
                r_out_gcid     <= w_inj_head[INJ_W-1:OFFSET_W];
                r_out_offset   <= w_inj_head[OFFSET_W-1:0];
            end else if (w_slot_free) begin
                r_out_lifetime <= '0;
                r_out_gcid     <= '0;
                r_out_offset   <= '0;
            end else begin
                r_out_lifetime <= w_fwd_lt;
                r_out_gcid     <= i_ring_gcid;
                r_out_offset   <= i_ring_offset_pkt;
            end

            r_dirty <= w_defer;
            if (w_defer && (r_retry_count != 16'hFFFF))
                r_retry_count <= r_retry_count + 16'd1;
        end
    end

    assign o_local_ready         = !r_inj_full;
    assign o_offset_pkt_to_ring  = r_out_offset;
    assign o_gcid_to_ring        = r_out_gcid;
    assign o_lifetime_to_ring    = r_out_lifetime;
    assign o_pos_pkt_to_pe_valid = (r_pe_count != '0);
    assign o_pos_pkt_to_pe       = o_pos_pkt_to_pe_valid ? r_pe_mem[r_pe_rd_ptr] : '0;
    assign o_dirty_feedback      = r_dirty;
    assign o_retry_count         = r_retry_count;

endmodule
